// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM port arbiter.
// State and grant encodings are visible to checkers through the debug port.
package sram_arb_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

    typedef logic [0:0] state_t;
    localparam state_t S_INIT = 1'b0;
    localparam state_t S_IDLE = 1'b1;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Request, response and SRAM-side signals of the arbiter grouped in one bundle.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; valid never waits on ready.
interface sram_port_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              r_req_valid;
    logic              r_req_ready;
    logic [ADDR_W-1:0] r_req_addr;
    logic              w_req_valid;
    logic              w_req_ready;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_data;
    logic [DATA_W-1:0] w_req_mask;
    logic              r_resp_valid;
    logic              r_resp_ready;
    logic [DATA_W-1:0] r_resp_data;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              init_done;

    modport slave (
        input  r_req_valid, r_req_addr, w_req_valid, w_req_addr, w_req_data, w_req_mask,
        input  r_resp_ready, sram_rdata,
        output r_req_ready, w_req_ready, r_resp_valid, r_resp_data,
        output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata, init_done
    );

    modport master (
        output r_req_valid, r_req_addr, w_req_valid, w_req_addr, w_req_data, w_req_mask,
        output r_resp_ready, sram_rdata,
        input  r_req_ready, w_req_ready, r_resp_valid, r_resp_data,
        input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata, init_done
    );

endinterface

// File: rtl/sram_arb_resp_buf.sv
// One-entry read response holder: forwards SRAM data in its first cycle, then replays
// the captured copy so later writes to the array cannot disturb an unaccepted response.
module sram_arb_resp_buf #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_issue,
    input  logic              i_resp_ready,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_data
);

    logic              r_valid;
    logic              r_first;
    logic [DATA_W-1:0] r_buf;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_buf   <= '0;
        end else begin
            r_first <= i_issue;
            if (i_issue) begin
                r_valid <= 1'b1;
            end else if (i_resp_ready) begin
                r_valid <= 1'b0;
            end
            // Capture at the end of the bypass cycle, before any later write alters sram_rdata.
            if (r_first) begin
                r_buf <= i_rdata;
            end
        end
    end

    assign o_resp_valid = r_valid;
    assign o_resp_data  = r_first ? i_rdata : r_buf;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port, bit-masked SRAM between a read and a write requester (round-robin on tie).
// Define SRAM_ARB_RESET_CLEAR_EN to zero-fill the whole array after reset before arbitration opens.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic               clock,
    input  logic               reset,
    sram_port_arbiter_if.slave bus,
    output state_t             o_dbg_state
);

    state_t            r_state;
    logic              r_init_done;
    grant_e            r_last_grant;
`ifdef SRAM_ARB_RESET_CLEAR_EN
    logic [ADDR_W-1:0] r_init_ptr;
`endif

    logic              w_open;
    logic              w_rd_ok;
    logic              w_conflict;
    logic              w_gnt_rd;
    logic              w_gnt_wr;
    logic              w_resp_valid;
    logic [DATA_W-1:0] w_resp_data;
    logic              w_en;
    logic              w_wmode;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wmask;
    logic [DATA_W-1:0] w_wdata;

    assign w_open     = (r_state == S_IDLE) && r_init_done;
    assign w_rd_ok    = bus.r_req_valid && (!w_resp_valid || bus.r_resp_ready);
    assign w_conflict = w_open && w_rd_ok && bus.w_req_valid;

    always_comb begin
        w_gnt_rd = 1'b0;
        w_gnt_wr = 1'b0;
        if (w_conflict) begin
            w_gnt_rd = (r_last_grant == GNT_WR);
            w_gnt_wr = (r_last_grant == GNT_RD);
        end else if (w_open) begin
            w_gnt_rd = w_rd_ok;
            w_gnt_wr = bus.w_req_valid;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
`ifdef SRAM_ARB_RESET_CLEAR_EN
            r_state    <= S_INIT;
            r_init_ptr <= '0;
`else
            r_state    <= S_IDLE;
`endif
            r_init_done  <= 1'b0;
            r_last_grant <= GNT_WR;
        end else begin
`ifdef SRAM_ARB_RESET_CLEAR_EN
            if (r_state == S_INIT) begin
                // The pointer reaches all-ones on the last write and wraps to 0 exactly at the exit.
                r_init_ptr <= r_init_ptr + ADDR_W'(1);
                if (r_init_ptr == '1) begin
                    r_state     <= S_IDLE;
                    r_init_done <= 1'b1;
                end
            end
`else
            r_init_done <= 1'b1;
`endif
            if (w_conflict) begin
                r_last_grant <= w_gnt_rd ? GNT_RD : GNT_WR;
            end
        end
    end

    always_comb begin
        w_en    = 1'b0;
        w_wmode = 1'b0;
        w_addr  = '0;
        w_wmask = '0;
        w_wdata = '0;
`ifdef SRAM_ARB_RESET_CLEAR_EN
        if ((r_state == S_INIT) && !reset) begin
            w_en    = 1'b1;
            w_wmode = 1'b1;
            w_addr  = r_init_ptr;
            w_wmask = '1;
        end else
`endif
        if (w_gnt_wr) begin
            w_en    = 1'b1;
            w_wmode = 1'b1;
            w_addr  = bus.w_req_addr;
            w_wmask = bus.w_req_mask;
            w_wdata = bus.w_req_data;
        end else if (w_gnt_rd) begin
            w_en    = 1'b1;
            w_addr  = bus.r_req_addr;
        end
    end

    sram_arb_resp_buf #(
        .DATA_W(DATA_W)
    ) u_resp_buf (
        .i_clk        (clock),
        .i_rst        (reset),
        .i_issue      (w_gnt_rd),
        .i_resp_ready (bus.r_resp_ready),
        .i_rdata      (bus.sram_rdata),
        .o_resp_valid (w_resp_valid),
        .o_resp_data  (w_resp_data)
    );

    assign bus.r_req_ready  = w_gnt_rd;
    assign bus.w_req_ready  = w_gnt_wr;
    assign bus.r_resp_valid = w_resp_valid;
    assign bus.r_resp_data  = w_resp_data;
    assign bus.sram_en      = w_en;
    assign bus.sram_wmode   = w_wmode;
    assign bus.sram_addr    = w_addr;
    assign bus.sram_wmask   = w_wmask;
    assign bus.sram_wdata   = w_wdata;
    assign bus.init_done    = r_init_done;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM, array/queue reference model, directed then random traffic.
// Works with or without SRAM_ARB_RESET_CLEAR_EN defined.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    state_t     dbg_state;
    logic       mon_en = 1'b0;
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] mem     [128];
    logic [7:0] ref_mem [128];
    logic [7:0] exp_q [$];
    logic       r_took;
    logic       w_took;

    sram_port_arbiter_if bus ();

    sram_port_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- comparison ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {bus.r_req_ready, bus.w_req_ready, bus.r_resp_valid, bus.r_resp_data,
                    bus.init_done, bus.sram_en}, 32'h0);
    endtask

    // ---------------- SRAM macro model: 1-cycle read, rdata scrambled by writes ----------------
    always @(posedge clock) begin
        if (bus.sram_en) begin
            if (bus.sram_wmode) begin
                mem[bus.sram_addr] = (mem[bus.sram_addr] & ~bus.sram_wmask) |
                                     (bus.sram_wdata & bus.sram_wmask);
                bus.sram_rdata <= 8'($urandom);
            end else begin
                bus.sram_rdata <= mem[bus.sram_addr];
            end
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic m_last_wr;
    always @(negedge clock) begin : monitor
        logic rd_ok, wr_ok, g_rd, g_wr;
        if (reset || !mon_en) begin
            m_last_wr = 1'b1;
            exp_q.delete();
        end else begin
            rd_ok = bus.r_req_valid && ((exp_q.size() == 0) || bus.r_resp_ready);
            wr_ok = bus.w_req_valid;
            g_rd  = rd_ok && (!wr_ok || m_last_wr);
            g_wr  = wr_ok && (!rd_ok || !m_last_wr);
            check("r_req_ready", bus.r_req_ready, g_rd);
            check("w_req_ready", bus.w_req_ready, g_wr);
            if (g_wr)
                check("sram_write_drive", {bus.sram_en, bus.sram_wmode, bus.sram_addr, bus.sram_wmask, bus.sram_wdata},
                      {2'b11, bus.w_req_addr, bus.w_req_mask, bus.w_req_data});
            else if (g_rd)
                check("sram_read_drive", {bus.sram_en, bus.sram_wmode, bus.sram_addr}, {2'b10, bus.r_req_addr});
            else
                check("sram_idle_drive", {bus.sram_en, bus.sram_wmode, bus.sram_addr, bus.sram_wmask, bus.sram_wdata}, 32'h0);
            check("r_resp_valid", bus.r_resp_valid, (exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("r_resp_data", bus.r_resp_data, exp_q[0]);
                if (bus.r_resp_ready) void'(exp_q.pop_front());
            end
            if (rd_ok && wr_ok) m_last_wr = g_wr;
            if (g_rd) exp_q.push_back(ref_mem[bus.r_req_addr]);
            if (g_wr) ref_mem[bus.w_req_addr] = (ref_mem[bus.w_req_addr] & ~bus.w_req_mask) |
                                                (bus.w_req_data & bus.w_req_mask);
        end
    end

    // ---------------- driver tasks (called at posedge+1, return at posedge+1) ----------------
    task automatic do_write(input logic [6:0] a, input logic [7:0] d, input logic [7:0] m);
        logic got = 1'b0;
        bus.w_req_valid = 1'b1;
        bus.w_req_addr  = a;
        bus.w_req_data  = d;
        bus.w_req_mask  = m;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clock);
            got = bus.w_req_ready;
            @(posedge clock);
            #1;
        end
        bus.w_req_valid = 1'b0;
        check("write_grant", got, 1'b1);
    endtask

    task automatic do_read(input logic [6:0] a);
        logic got = 1'b0;
        bus.r_req_valid = 1'b1;
        bus.r_req_addr  = a;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clock);
            got = bus.r_req_ready;
            @(posedge clock);
            #1;
        end
        bus.r_req_valid = 1'b0;
        check("read_grant", got, 1'b1);
    endtask

    task automatic expect_resp(input string tag, input logic [7:0] exp);
        @(negedge clock);
        check({tag, "_valid"}, bus.r_resp_valid, 1'b1);
        check({tag, "_data"}, bus.r_resp_data, exp);
        @(posedge clock);
        #1;
    endtask

`ifdef SRAM_ARB_RESET_CLEAR_EN
    task automatic run_sweep(input int stop_at);
        for (int i = 0; i < 128; i++) begin
            @(negedge clock);
            check("init_sweep", {bus.sram_en, bus.sram_wmode, bus.sram_addr, bus.sram_wmask, bus.sram_wdata,
                                 bus.r_req_ready, bus.w_req_ready, bus.init_done},
                  {2'b11, 7'(i), 8'hFF, 8'h00, 3'b000});
            if (i == stop_at) return;
        end
        @(negedge clock);
        check("init_done_after_sweep", {bus.init_done, dbg_state}, {1'b1, S_IDLE});
        @(posedge clock);
        #1;
    endtask
`endif

    // Called at posedge+1 right after reset release; returns at posedge+1 with arbitration open.
    task automatic open_arb();
`ifdef SRAM_ARB_RESET_CLEAR_EN
        run_sweep(-1);
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
`else
        @(negedge clock);
        check("init_done_before_edge", bus.init_done, 1'b0);
        @(posedge clock);
        #1;
        check("init_done_after_edge", {bus.init_done, dbg_state}, {1'b1, S_IDLE});
`endif
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] bb [3];
        bb = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        reset            = 1'b1;
        bus.r_req_valid  = 1'b0;
        bus.r_req_addr   = '0;
        bus.w_req_valid  = 1'b0;
        bus.w_req_addr   = '0;
        bus.w_req_data   = '0;
        bus.w_req_mask   = '0;
        bus.r_resp_ready = 1'b1;
        #12;
        check_reset_outputs("reset_values");
        @(posedge clock);
        #1;
        reset = 1'b0;

`ifdef SRAM_ARB_RESET_CLEAR_EN
        // Abort the sweep at init_ptr = 60; the next one must restart at 0.
        run_sweep(60);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid_init");
        check("state_mid_init_reset", dbg_state, S_INIT);
        @(posedge clock);
        #1;
        reset = 1'b0;
`endif
        open_arb();
        mon_en = 1'b1;

        // Full-mask write then partial-mask write, read back each.
        do_write(7'd5, 8'hA5, 8'hFF);
        do_read(7'd5);
        expect_resp("rd_after_wr", 8'hA5);
        do_write(7'd5, 8'h0F, 8'hF0);
        do_read(7'd5);
        expect_resp("rd_masked", 8'h05);

        // Both requesters held for 6 cycles: grants alternate starting with read.
        bus.r_req_valid = 1'b1;
        bus.r_req_addr  = 7'd11;
        bus.w_req_valid = 1'b1;
        bus.w_req_addr  = 7'd10;
        bus.w_req_data  = 8'h5A;
        bus.w_req_mask  = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("tie_alternation", {bus.r_req_ready, bus.w_req_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            @(posedge clock);
            #1;
            bus.w_req_data = 8'($urandom);
        end
        bus.r_req_valid = 1'b0;
        bus.w_req_valid = 1'b0;

        // Stalled response survives an overwrite of its address.
        do_write(7'd3, 8'h3C, 8'hFF);
        do_write(7'd7, 8'h77, 8'hFF);
        bus.r_resp_ready = 1'b0;
        do_read(7'd3);
        bus.r_req_valid = 1'b1;
        bus.r_req_addr  = 7'd7;
        bus.w_req_valid = 1'b1;
        bus.w_req_addr  = 7'd3;
        bus.w_req_data  = 8'hFF;
        bus.w_req_mask  = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("stall_resp", {bus.r_resp_valid, bus.r_resp_data, bus.r_req_ready}, {1'b1, 8'h3C, 1'b0});
            if (i == 0) check("stall_write_granted", bus.w_req_ready, 1'b1);
            @(posedge clock);
            #1;
            bus.w_req_valid = 1'b0;
        end
        bus.r_resp_ready = 1'b1;
        @(negedge clock);
        check("accept_and_regrant", {bus.r_resp_data, bus.r_req_ready}, {8'h3C, 1'b1});
        @(posedge clock);
        #1;
        bus.r_req_valid = 1'b0;
        expect_resp("rd_after_stall", 8'h77);
        do_read(7'd3);
        expect_resp("rd_overwritten", 8'hFF);

        // Back-to-back reads of 1,2,3 with no bubbles.
        do_write(7'd1, 8'h11, 8'hFF);
        do_write(7'd2, 8'h22, 8'hFF);
        do_write(7'd3, 8'h33, 8'hFF);
        bus.r_req_valid = 1'b1;
        bus.r_req_addr  = 7'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i < 3) check("b2b_ready", bus.r_req_ready, 1'b1);
            if (i > 0) check("b2b_resp", {bus.r_resp_valid, bus.r_resp_data}, {1'b1, bb[i-1]});
            @(posedge clock);
            #1;
            if (i < 2) bus.r_req_addr = bus.r_req_addr + 7'd1;
            else bus.r_req_valid = 1'b0;
        end

        // Random traffic on a small address window, checked by the monitor.
        r_took = 1'b0;
        w_took = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!bus.r_req_valid || r_took) begin
                bus.r_req_valid = 1'($urandom_range(0, 1));
                bus.r_req_addr  = 7'($urandom_range(0, 15));
            end
            if (!bus.w_req_valid || w_took) begin
                bus.w_req_valid = 1'($urandom_range(0, 1));
                bus.w_req_addr  = 7'($urandom_range(0, 15));
                bus.w_req_data  = 8'($urandom);
                bus.w_req_mask  = 8'($urandom);
            end
            bus.r_resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            r_took = bus.r_req_valid && bus.r_req_ready;
            w_took = bus.w_req_valid && bus.w_req_ready;
            @(posedge clock);
            #1;
        end
        bus.r_req_valid  = 1'b0;
        bus.w_req_valid  = 1'b0;
        bus.r_resp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Reset while a response is pending drops it immediately.
        bus.r_resp_ready = 1'b0;
        do_read(7'd9);
        @(negedge clock);
        check("pending_before_reset", bus.r_resp_valid, 1'b1);
        mon_en          = 1'b0;
        bus.w_req_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid_resp");
        bus.w_req_valid  = 1'b0;
        bus.r_resp_ready = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        open_arb();
        mon_en = 1'b1;
        do_read(7'd9);
        expect_resp("rd_after_reset", ref_mem[9]);

        repeat (2) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
